// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state type and byte-lane helper functions.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STORE     = 3'd1,
    LOAD      = 3'd2,
    LOAD_WAIT = 3'd3,
    RESP      = 3'd4
  } lsu_state_t;

  // Byte-enable pattern for an access of the size encoded in funct3[1:0],
  // moved to the lane selected by the low address bits.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] base;
    case (f3[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << lo;
  endfunction

  // Bit shift that moves byte lane 0 to lane lo.
  function automatic logic [4:0] lane_shift(input logic [1:0] lo);
    return {lo, 3'b000};
  endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Combinational lane steering: store data/mask placement onto the dmem
// word, and load byte/half/word extraction with sign or zero extension.
module rv32_lsu_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_mask,
  output logic [31:0] st_data_sh,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_sh;

  // Store side: mask and data placed on the addressed lane.
  always_comb begin
    st_mask    = store_mask(st_funct3, st_addr_lo);
    st_data_sh = st_data << lane_shift(st_addr_lo);
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_sh = ld_word >> lane_shift(ld_addr_lo);
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_H:    ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_W:    ld_data = ld_sh;
      F3_BU:   ld_data = {24'h0, ld_sh[7:0]};
      F3_HU:   ld_data = {16'h0, ld_sh[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// RV32I load/store unit, initiator side of the data-memory port.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. Once
// valid is raised, the payload stays stable until that transfer edge.
// One request is in flight at a time; req_ready is high only in IDLE.
module rv32_lsu
  import rv32_mem_pkg::*;
#(
  parameter int unsigned DMEM_BYTES   = 16384,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  output logic        rsp_fault,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  lsu_state_t  state_q, state_d;
  logic        accept, mis_c, illegal_c, range_c, err_c;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [3:0]  wmask_q;
  logic [3:0]  st_mask;
  logic [31:0] st_data_sh, ld_data;

  rv32_lsu_align u_align (
    .st_funct3  (req_funct3),
    .st_addr_lo (req_addr[1:0]),
    .st_data    (req_wdata),
    .st_mask    (st_mask),
    .st_data_sh (st_data_sh),
    .ld_funct3  (f3_q),
    .ld_addr_lo (lo_q),
    .ld_word    (mem_rdata),
    .ld_data    (ld_data)
  );

  // Request checks; misalignment outranks fault when both apply.
  always_comb begin
    accept    = req_valid && req_ready;
    mis_c     = (((req_funct3 == F3_H) || (!req_is_store && (req_funct3 == F3_HU))) && req_addr[0])
              || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    illegal_c = req_is_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                             : ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111));
    range_c   = req_addr >= 32'(DMEM_BYTES);
    err_c     = mis_c || illegal_c || range_c;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (err_c)             state_d = RESP;
          else if (req_is_store) state_d = STORE;
          else                   state_d = LOAD;
        end
      end
      STORE:     state_d = RESP;
      LOAD:      state_d = (READ_LATENCY == 0) ? RESP : LOAD_WAIT;
      LOAD_WAIT: state_d = RESP;
      RESP:      if (rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State-decoded outputs; write strobes exist only in STORE.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    mem_we    = (state_q == STORE);
    mem_wmask = (state_q == STORE) ? wmask_q : 4'b0000;
    dbg_state = state_q;
  end

  // Request latch, dmem drive registers and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q         <= 3'b000;
      lo_q         <= 2'b00;
      wmask_q      <= 4'b0000;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      rsp_rdata    <= 32'h0;
      rsp_misalign <= 1'b0;
      rsp_fault    <= 1'b0;
    end else begin
      if (accept) begin
        f3_q <= req_funct3;
        lo_q <= req_addr[1:0];
        if (err_c) begin
          rsp_misalign <= mis_c;
          rsp_fault    <= !mis_c;
          rsp_rdata    <= 32'h0;
        end else begin
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_wdata <= st_data_sh;
          wmask_q   <= st_mask;
        end
      end
      if (((state_q == LOAD) && (READ_LATENCY == 0)) || (state_q == LOAD_WAIT))
        rsp_rdata <= ld_data;
      if (state_q == STORE)
        rsp_rdata <= 32'h0;
      if ((state_q == RESP) && rsp_ready) begin
        rsp_rdata    <= 32'h0;
        rsp_misalign <= 1'b0;
        rsp_fault    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Bench for rv32_lsu: directed cases plus randomized traffic against a
// byte-addressed reference memory and a response expectation queue.
module tb_rv32_lsu;

  localparam int DMEM_BYTES = 16384;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_misalign, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  rv32_lsu #(.DMEM_BYTES(DMEM_BYTES), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_misalign(rsp_misalign), .rsp_fault(rsp_fault),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered data memory (one cycle read latency)
  logic [31:0] dmem [0:4095];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) dmem[mem_addr[13:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    rd_q <= dmem[mem_addr[13:2]];
  end
  assign mem_rdata = rd_q;

  // reference model state
  logic [7:0]  ref_mem [0:DMEM_BYTES-1];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  // results of the last transaction, for directed constant checks
  logic [31:0] last_rdata, last_wdata, last_addr;
  logic [3:0]  last_mask;
  int          last_lat, last_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: classify a request from the ISA rules.
  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_legal(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic bit ref_misalign(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit half, word;
    half = (f3 == 3'd1) || (!st && f3 == 3'd5);
    word = (f3 == 3'd2);
    return (half && (a % 2 != 0)) || (word && (a % 4 != 0));
  endfunction

  // Drive one request; observe the transaction; check against the model.
  task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int hold);
    bit mis, flt, ok;
    int sz, lat, we_cnt;
    logic [31:0] v, exp_rd, exp_wd, snap_rd;
    logic [3:0]  exp_mask;
    bit snap_mis, snap_flt, done;

    mis = ref_misalign(st, f3, a);
    flt = !mis && (!ref_legal(st, f3) || (a >= DMEM_BYTES));
    ok  = !mis && !flt;
    sz  = acc_size(f3);
    exp_mask = 4'((32'((1 << sz) - 1)) << (a % 4));
    exp_wd   = wd << (8 * (a % 4));
    exp_rd   = 32'h0;
    if (ok && !st) begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[i*8 +: 8] = ref_mem[a + i];
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      exp_rd = v;
    end
    if (ok && st)
      for (int i = 0; i < sz; i++) ref_mem[a + i] = wd[i*8 +: 8];
    exp_q.push_back(exp_rd);

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0; we_cnt = 0; done = 0;
    last_mask = 4'h0; last_wdata = 32'h0; last_addr = 32'h0;
    while (!done) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && ok) last_addr = mem_addr;
      if (mem_we) begin
        we_cnt++;
        last_mask = mem_wmask; last_wdata = mem_wdata; last_addr = mem_addr;
      end
      if (!ok || lat >= 2) check("mem_addr_stable", mem_addr, ok ? {a[31:2], 2'b00} : mem_addr);
      if (rsp_valid) done = 1;
      else if (lat > 8) begin
        check("rsp_timeout", 32'(lat), 32'd0);
        done = 1;
      end
    end
    last_lat = lat; last_we = we_cnt; last_rdata = rsp_rdata;

    check("rsp_latency", 32'(lat), ok ? (st ? 32'd2 : 32'd3) : 32'd1);
    check("rsp_misalign", 32'(rsp_misalign), 32'(mis));
    check("rsp_fault", 32'(rsp_fault), 32'(flt));
    check("rsp_rdata", rsp_rdata, exp_q.pop_front());
    check("mem_we_cycles", 32'(we_cnt), (ok && st) ? 32'd1 : 32'd0);
    if (ok) check("mem_addr", last_addr, {a[31:2], 2'b00});
    if (ok && st) begin
      check("mem_wmask", 32'(last_mask), 32'(exp_mask));
      check("mem_wdata", last_wdata, exp_wd);
    end

    // backpressure: response held stable, further requests ignored
    snap_rd = rsp_rdata; snap_mis = rsp_misalign; snap_flt = rsp_fault;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h0BAD0BAD;
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rdata", rsp_rdata, snap_rd);
      check("hold_flags", {30'h0, rsp_misalign, rsp_fault}, {30'h0, snap_mis, snap_flt});
      check("hold_no_we", 32'(mem_we), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("release_rsp_valid", 32'(rsp_valid), 32'd0);
    check("release_req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  // Start a request and pull reset after cut_lat cycles; nothing may commit.
  task automatic reset_mid(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int cut_lat);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < cut_lat; i++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_mem_we", 32'(mem_we), 32'd0);
    check("rst_mid_wmask", 32'(mem_wmask), 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'h0);
    check("rst_mid_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 4096; i++) begin
      w = $urandom;
      dmem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[i*4 + b] = w[b*8 +: 8];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_flags", {30'h0, rsp_misalign, rsp_fault}, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases with literal expectations
    txn(1, 3'd2, 32'h100, 32'hDEADBEEF, 0);
    check("sw_mask", 32'(last_mask), 32'hF);
    check("sw_wdata", last_wdata, 32'hDEADBEEF);
    check("sw_addr", last_addr, 32'h100);
    txn(1, 3'd2, 32'h100, 32'h80011234, 0);
    txn(0, 3'd1, 32'h102, 32'h0, 0);
    check("lh_val", last_rdata, 32'hFFFF8001);
    txn(0, 3'd5, 32'h102, 32'h0, 0);
    check("lhu_val", last_rdata, 32'h00008001);
    txn(0, 3'd2, 32'h100, 32'h0, 0);
    check("lw_val", last_rdata, 32'h80011234);
    check("lw_lat", 32'(last_lat), 32'd3);
    txn(1, 3'd0, 32'h103, 32'h000000A5, 0);
    check("sb_mask", 32'(last_mask), 32'h8);
    check("sb_wdata", last_wdata, 32'hA5000000);
    txn(0, 3'd0, 32'h103, 32'h0, 0);
    check("lb_val", last_rdata, 32'hFFFFFFA5);
    txn(0, 3'd4, 32'h103, 32'h0, 0);
    check("lbu_val", last_rdata, 32'h000000A5);
    txn(0, 3'd2, 32'h101, 32'h0, 0);
    check("lw_mis_lat", 32'(last_lat), 32'd1);
    txn(0, 3'd3, 32'h100, 32'h0, 0);
    txn(1, 3'd2, 32'h4000, 32'h12345678, 0);
    txn(1, 3'd2, 32'h3FFC, 32'h12345678, 0);
    txn(0, 3'd2, 32'h3FFC, 32'h0, 0);
    check("top_word", last_rdata, 32'h12345678);
    txn(1, 3'd5, 32'h20, 32'h1, 0);
    txn(0, 3'd2, 32'h104, 32'h0, 3);

    // reset during LOAD_WAIT, then a store cut in its STORE cycle
    reset_mid(0, 3'd2, 32'h100, 32'h0, 2);
    txn(0, 3'd2, 32'h100, 32'h0, 0);
    reset_mid(1, 3'd2, 32'h200, 32'hCAFEF00D, 1);
    txn(0, 3'd2, 32'h200, 32'h0, 0);

    // randomized traffic over a small window plus occasional out-of-range
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(DMEM_BYTES, DMEM_BYTES + 4096))
                                      : 32'($urandom_range(0, 63));
      txn($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
